// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, transmit FSM state encoding and
// the clocks-per-bit helper used by the transmit path.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// 8N1 frame sequencer: baud counter, LSB-first shift register and FSM.
// ready_o is high in IDLE and in the last STOP cycle, where start_i loads a new byte.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 1250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [UART_DATA_BITS-1:0] data_i,
    output logic                      ready_o,
    output logic                      busy_o,
    output logic                      tx_o
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      bit_last;

    assign bit_last = (cnt_q == CNT_LAST);
    assign ready_o  = (state_q == IDLE) || ((state_q == STOP) && bit_last);
    assign busy_o   = busy_q;
    assign tx_o     = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        if (state_q != IDLE) begin
            cnt_d = bit_last ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    cnt_d   = '0;
                    sh_d    = data_i;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_last) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            DATA: begin
                if (bit_last) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            STOP: begin
                // A start here chains the next frame with no idle gap.
                if (bit_last) begin
                    if (start_i) begin
                        state_d = START;
                        cnt_d   = '0;
                        sh_d    = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX pin between NUM_REQ byte sources.
// Define UART_TX_ARB_ACT_LED_EN to add the act_led TX activity stretcher output.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 9600,
    parameter int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [UART_DATA_BITS*NUM_REQ-1:0]  data,
    output logic [NUM_REQ-1:0]                 ack,
    output logic                               busy,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
`ifdef UART_TX_ARB_ACT_LED_EN
    output logic                               act_led,
`endif
    output logic                               uarttx
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_arbiter: BAUD_DIV must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [ID_W-1:0]    scan_idx;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;
    logic               frame_ready;
    logic               grant;

    // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    assign grant = win_vld && frame_ready;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        if (grant) begin
            ack_d      = NUM_REQ'(1) << win_id;
            grant_id_d = win_id;
            rr_ptr_d   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_id_q;

    uart_tx_frame #(
        .BAUD_DIV (BAUD_DIV)
    ) u_frame (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (grant),
        .data_i  (data[{win_id, 3'b000} +: UART_DATA_BITS]),
        .ready_o (frame_ready),
        .busy_o  (busy),
        .tx_o    (uarttx)
    );

`ifdef UART_TX_ARB_ACT_LED_EN
    logic        led_q, led_d;
    logic [15:0] led_cnt_q, led_cnt_d;

    // Stretch counts only once the line is idle, so the hold is measured from the stop bit's end.
    always_comb begin
        led_d     = led_q;
        led_cnt_d = led_cnt_q;
        if (grant) begin
            led_d     = 1'b1;
            led_cnt_d = '0;
        end else if (led_q && !busy) begin
            if (led_cnt_q == 16'hFFFF) begin
                led_d = 1'b0;
            end else begin
                led_cnt_d = led_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q     <= 1'b0;
            led_cnt_q <= '0;
        end else begin
            led_q     <= led_d;
            led_cnt_q <= led_cnt_d;
        end
    end

    assign act_led = led_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with BAUD_DIV=16, NUM_REQ=4.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BD      = 16;
    localparam int FRAME   = 10 * BD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        uarttx;
`ifdef UART_TX_ARB_ACT_LED_EN
    logic        act_led;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
`ifdef UART_TX_ARB_ACT_LED_EN
        .act_led  (act_led),
`endif
        .uarttx   (uarttx)
    );

    always #5 clk = ~clk;

    // Line level for bit slot 0..9 of an 8N1 frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({uarttx, busy, ack, grant_id} !== {1'b1, 1'b0, 4'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_hold: got tx/busy/ack/gid=%b/%b/%b/%0d want 1/0/0000/0",
                     uarttx, busy, ack, grant_id);
        end
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        tests_run++;
        if (uarttx !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_tx: got %b want 1", uarttx);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
        tests_run++;
        if (ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL idle_ack: got %b want 0000", ack);
        end
        tests_run++;
        if (grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL idle_gid: got %0d want 0", grant_id);
        end
    endtask

    task automatic test_single_frame();
        logic seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        data[23:16] = 8'hA5;
        req = 4'b0100;
        @(negedge clk);
        tests_run++;
        if ({ack, grant_id} !== {4'b0100, 2'd2}) begin
            tests_failed++;
            $display("FAIL single_ack: got ack=%b gid=%0d want 0100/2", ack, grant_id);
        end
        req = '0;
        for (int c = 0; c < FRAME; c++) begin
            tests_run++;
            if ({busy, uarttx} !== {1'b1, seq[c/BD]}) begin
                tests_failed++;
                $display("FAIL single_line c=%0d: got busy/tx=%b/%b want 1/%b",
                         c, busy, uarttx, seq[c/BD]);
            end
            if (c == 1) begin
                tests_run++;
                if (ack !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL single_ack_pulse: got %b want 0000", ack);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if ({busy, uarttx} !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_end: got busy/tx=%b/%b want 0/1", busy, uarttx);
        end
    endtask

    task automatic test_back_to_back();
        int   order [5] = '{0, 1, 2, 3, 0};
        int   id;
        logic [3:0] exp_ack;
        logic exp_tx;
        rst_n = 1'b0;
        data  = 32'h33221100;
        req   = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5 * FRAME; c++) begin
            id      = order[c / FRAME];
            exp_ack = (c % FRAME == 0) ? (4'b0001 << id) : 4'b0000;
            exp_tx  = exp_bit(data[8*id +: 8], (c % FRAME) / BD);
            tests_run++;
            if ({ack, busy, uarttx, grant_id} !== {exp_ack, 1'b1, exp_tx, 2'(id)}) begin
                tests_failed++;
                $display("FAIL rr c=%0d: got ack=%b busy=%b tx=%b gid=%0d want %b/1/%b/%0d",
                         c, ack, busy, uarttx, grant_id, exp_ack, exp_tx, id);
            end
            if (c == 4 * FRAME + 1) req = '0;
            @(negedge clk);
        end
        tests_run++;
        if ({ack, busy, uarttx} !== {4'b0000, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rr_end: got ack=%b busy=%b tx=%b want 0000/0/1", ack, busy, uarttx);
        end
    endtask

    task automatic test_dropped_req();
        logic exp_tx;
        logic exp_busy;
        data[7:0] = 8'h3C;
        req = 4'b0001;
        @(negedge clk);
        tests_run++;
        if ({ack, grant_id, uarttx} !== {4'b0001, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL drop_first_ack: got ack=%b gid=%0d tx=%b want 0001/0/0",
                     ack, grant_id, uarttx);
        end
        req = '0;
        for (int c = 1; c < FRAME + 20; c++) begin
            @(negedge clk);
            exp_busy = (c < FRAME);
            exp_tx   = (c < FRAME) ? exp_bit(8'h3C, c / BD) : 1'b1;
            tests_run++;
            if ({ack, busy, uarttx, grant_id} !== {4'b0000, exp_busy, exp_tx, 2'd0}) begin
                tests_failed++;
                $display("FAIL drop c=%0d: got ack=%b busy=%b tx=%b gid=%0d want 0000/%b/%b/0",
                         c, ack, busy, uarttx, grant_id, exp_busy, exp_tx);
            end
            if (c == 40) req[1] = 1'b1;
            if (c == 45) req[1] = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        data[23:16] = 8'hFF;
        req = 4'b0100;
        @(negedge clk);
        tests_run++;
        if (ack !== 4'b0100) begin
            tests_failed++;
            $display("FAIL mid_ack: got %b want 0100", ack);
        end
        req = '0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({uarttx, busy, ack} !== {1'b1, 1'b0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL mid_async_reset: got tx/busy/ack=%b/%b/%b want 1/0/0000",
                     uarttx, busy, ack);
        end
        data[7:0]   = 8'h5A;
        data[31:24] = 8'hC3;
        req = 4'b1001;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({ack, grant_id, uarttx} !== {4'b0001, 2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got ack=%b gid=%0d tx=%b want 0001/0/0",
                     ack, grant_id, uarttx);
        end
        req = 4'b1000;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            if (c == FRAME - 1) begin
                tests_run++;
                if ({busy, uarttx, ack} !== {1'b1, 1'b1, 4'b0000}) begin
                    tests_failed++;
                    $display("FAIL post_reset_stop: got busy/tx/ack=%b/%b/%b want 1/1/0000",
                             busy, uarttx, ack);
                end
            end
            if (c == FRAME) begin
                tests_run++;
                if ({ack, grant_id, busy, uarttx} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL post_reset_next: got ack=%b gid=%0d busy=%b tx=%b want 1000/3/1/0",
                             ack, grant_id, busy, uarttx);
                end
            end
        end
        req = '0;
        repeat (FRAME + 5) @(negedge clk);
        tests_run++;
        if ({busy, uarttx} !== 2'b01) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got busy/tx=%b/%b want 0/1", busy, uarttx);
        end
    endtask

`ifdef UART_TX_ARB_ACT_LED_EN
    task automatic test_act_led();
        int cnt;
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        tests_run++;
        if (act_led !== 1'b0) begin
            tests_failed++;
            $display("FAIL led_reset: got %b want 0", act_led);
        end
        rst_n = 1'b1;
        @(negedge clk);
        data[15:8] = 8'h81;
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        cnt = 0;
        while (act_led === 1'b1 && cnt < 70000) begin
            cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (cnt != FRAME + 65536) begin
            tests_failed++;
            $display("FAIL led_stretch: got %0d cycles high want %0d", cnt, FRAME + 65536);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_dropped_req();
        test_reset_midframe();
`ifdef UART_TX_ARB_ACT_LED_EN
        test_act_led();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
